// File: rtl/irq_arbiter.sv
// Machine-mode interrupt arbiter: synchronises raw lines into mip, picks the
// highest-priority enabled pending source and requests a trap via req/ack.
module irq_arbiter #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ext_irq,
    input  logic        timer_irq,
    input  logic        sw_irq,
    input  logic [31:0] mie,
    input  logic        mstatus_mie,
    input  logic [31:0] mip_in,
    input  logic        wr_mip_n,
    input  logic        irq_ack,
    input  logic        mret,
    output logic [31:0] mip,
    output logic        irq_req,
    output logic [31:0] irq_cause,
    output logic        in_handler
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        HANDLER = 2'd2
    } state_t;

    // Software-writable S/U pending bits: SEIP, UEIP, STIP, UTIP, SSIP, USIP.
    localparam logic [31:0] SU_MASK = 32'h0000_0333;

    logic [SYNC_STAGES-1:0] ext_sync_q, ext_sync_d;
    logic [SYNC_STAGES-1:0] timer_sync_q, timer_sync_d;
    logic [SYNC_STAGES-1:0] sw_sync_q, sw_sync_d;
    logic [31:0]            su_q, su_d;
    state_t                 state_q, state_d;
    logic                   irq_req_q, irq_req_d;
    logic                   in_handler_q, in_handler_d;
    logic [31:0]            irq_cause_q, irq_cause_d;
    logic [31:0]            pending;
    logic [3:0]             win_code;
    logic                   arm;

    always_comb begin
        ext_sync_d      = ext_sync_q;
        timer_sync_d    = timer_sync_q;
        sw_sync_d       = sw_sync_q;
        ext_sync_d[0]   = ext_irq;
        timer_sync_d[0] = timer_irq;
        sw_sync_d[0]    = sw_irq;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            ext_sync_d[i]   = ext_sync_q[i-1];
            timer_sync_d[i] = timer_sync_q[i-1];
            sw_sync_d[i]    = sw_sync_q[i-1];
        end
        su_d = wr_mip_n ? su_q : (mip_in & SU_MASK);
    end

    assign mip = su_q | {20'b0, ext_sync_q[SYNC_STAGES-1], 3'b0,
                         timer_sync_q[SYNC_STAGES-1], 3'b0,
                         sw_sync_q[SYNC_STAGES-1], 3'b0};

    assign pending = mip & mie;
    assign arm     = mstatus_mie && (|pending);

    // Machine sources first, with software ahead of timer; the code equals the mip bit index.
    always_comb begin
        win_code = 4'd0;
        if      (pending[11]) win_code = 4'd11;
        else if (pending[3])  win_code = 4'd3;
        else if (pending[7])  win_code = 4'd7;
        else if (pending[9])  win_code = 4'd9;
        else if (pending[1])  win_code = 4'd1;
        else if (pending[5])  win_code = 4'd5;
        else if (pending[8])  win_code = 4'd8;
        else if (pending[0])  win_code = 4'd0;
        else if (pending[4])  win_code = 4'd4;
    end

    always_comb begin
        state_d     = state_q;
        irq_cause_d = irq_cause_q;
        case (state_q)
            IDLE: begin
                if (arm) begin
                    irq_cause_d = {1'b1, 27'b0, win_code};
                    state_d     = REQ;
                end
            end
            REQ: begin
                if (irq_ack)   state_d = HANDLER;
                else if (!arm) state_d = IDLE;
            end
            HANDLER: begin
                if (mret) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        irq_req_d    = (state_d == REQ);
        in_handler_d = (state_d == HANDLER);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ext_sync_q   <= '0;
            timer_sync_q <= '0;
            sw_sync_q    <= '0;
            su_q         <= '0;
            state_q      <= IDLE;
            irq_req_q    <= 1'b0;
            in_handler_q <= 1'b0;
            irq_cause_q  <= '0;
        end else begin
            ext_sync_q   <= ext_sync_d;
            timer_sync_q <= timer_sync_d;
            sw_sync_q    <= sw_sync_d;
            su_q         <= su_d;
            state_q      <= state_d;
            irq_req_q    <= irq_req_d;
            in_handler_q <= in_handler_d;
            irq_cause_q  <= irq_cause_d;
        end
    end

    assign irq_req    = irq_req_q;
    assign in_handler = in_handler_q;
    assign irq_cause  = irq_cause_q;

endmodule
